// File: rtl/serial_in_parallel_out_deserializer_pkg.sv
// Shared constants and helpers for the serial-in / parallel-out deserializer.
// Holds the default word width, the output buffer depth and a clog2 helper.
package serial_in_parallel_out_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int BUF_DEPTH     = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_in_parallel_out_deserializer_word_fifo2.sv
// Purpose: two-entry word FIFO; dout always presents the head entry.
// Latency: a push into an empty FIFO is visible on dout/valid right after the edge.
// Backpressure: push while full without a pop is dropped; push+pop is accepted at any occupancy.
module word_fifo2
    import serial_in_parallel_out_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             C,
    input  logic             R,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop_ok;

    assign pop_ok = pop & (count_q != 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = din;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop_ok) begin
                    head_d = din;
                end else if (push) begin
                    tail_d  = din;
                    count_d = 2'd2;
                end else if (pop_ok) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // Full: a push is only taken when the head leaves on the same edge.
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = din;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign valid = (count_q != 2'd0);
    assign full  = (count_q == 2'(BUF_DEPTH));

endmodule

// File: rtl/serial_in_parallel_out_deserializer.sv
// Purpose: reassembles an MSB-first, SE-qualified serial stream into WIDTH-bit words.
// Latency: word visible on DOUT/DVALID right after the edge that samples its last bit.
// Backpressure: 2-entry buffer with DVALID/DREADY; a word arriving when full is dropped and OVF sticks.
module serial_in_parallel_out_deserializer
    import serial_in_parallel_out_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             C,
    input  logic             R,
    input  logic             SI,
    input  logic             SE,
    input  logic             SYNC,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             BUSY,
    output logic             FERR,
    output logic             OVF
);

    localparam int             CW       = clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    // The oldest bit is never read back once shifted past WIDTH-1 positions,
    // so only the low WIDTH-1 bits of the shift register are kept.
    logic [WIDTH-2:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] shift_word;
    logic             word_push;
    logic             fifo_full;

    assign shift_word = {sreg_q, SI};

    always_comb begin
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        ferr_d    = 1'b0;
        word_push = 1'b0;
        if (SE) begin
            if (SYNC) begin
                // Realign: this bit is a new MSB; any partial word is abandoned.
                sreg_d    = '0;
                sreg_d[0] = SI;
                cnt_d     = CNT_ONE;
                ferr_d    = (cnt_q != '0);
            end else begin
                sreg_d = shift_word[WIDTH-2:0];
                if (cnt_q == CNT_LAST) begin
                    word_push = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign ovf_d = ovf_q | (word_push & fifo_full & ~DREADY);

    always_ff @(posedge C) begin
        if (R) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
        end
    end

    word_fifo2 #(
        .WIDTH (WIDTH)
    ) u_word_fifo2 (
        .C     (C),
        .R     (R),
        .push  (word_push),
        .din   (shift_word),
        .pop   (DREADY),
        .dout  (DOUT),
        .valid (DVALID),
        .full  (fifo_full)
    );

    assign BUSY = busy_q;
    assign FERR = ferr_q;
    assign OVF  = ovf_q;

endmodule
